adc_spi_responder: RTL and testbench

Synthesizable responder for the ADC serial port: plays the converter's side of the CONVST/SCK/SDI/SDO interface for FPGA loopback and bring-up of the ADC reader without a physical converter. It latches a 12-bit sample on each CONVST rising edge and models a fixed conversion time. It then shifts the sample MSB-first on SDO while capturing the 6-bit configuration word on SDI. The captured word selects the channel for the next conversion.

---
 rtl/adc_spi_if.sv | 9 +
 rtl/adc_spi_responder.sv | 92 +++++++++
 tb/tb_adc_spi_responder.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/adc_spi_if.sv
// adc_spi_if: serial lines between the ADC reader (master) and the converter side (slave)
interface adc_spi_if;
  logic CONVST;
  logic SCK;
  logic SDI;
  logic SDO;
  modport master(output CONVST, SCK, SDI, input SDO);
  modport slave(input CONVST, SCK, SDI, output SDO);
endinterface

// File: rtl/adc_spi_responder.sv
// adc_spi_responder: converter-side model that latches a sample, waits a fixed conversion time and shifts it out while capturing the config word
module adc_spi_responder #(
  parameter int CONV_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  adc_spi_if.slave    bus,
  input  logic [11:0] sample_in,
  output logic        busy,
  output logic [2:0]  chan,
  output logic [5:0]  cfg_word,
  output logic        cfg_valid,
  output logic        sck_early
);
  localparam int CW = $clog2(CONV_CYCLES);
  typedef enum logic [1:0] {IDLE, CONVERT, READY, SHIFT} state_t;
  state_t state, state_d;
  logic [2:0] conv_q, sck_q;
  logic [1:0] sdi_q;
  logic [CW-1:0] cnt;
  logic [11:0] shift;
  logic [2:0] bit_cnt;
  logic [5:0] cfg_part;
  logic sdo, conv_rise, sck_rise, conv_done, shift_en;
  assign conv_rise = conv_q[1] & ~conv_q[2];
  assign sck_rise = sck_q[1] & ~sck_q[2] & ~conv_rise;
  assign conv_done = state == CONVERT && cnt == CW'(CONV_CYCLES - 1);
  assign shift_en = sck_rise && (state == READY || state == SHIFT);
  assign bus.SDO = sdo;
  // two-flop synchronizers plus a third stage for edge detection
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      conv_q <= '0;
      sck_q <= '0;
      sdi_q <= '0;
    end else begin
      conv_q <= {conv_q[1:0], bus.CONVST};
      sck_q <= {sck_q[1:0], bus.SCK};
      sdi_q <= {sdi_q[0], bus.SDI};
    end
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_d;
  // next state; a CONVST rise restarts conversion from any state
  always_comb begin
    state_d = state;
    busy = state == CONVERT;
    state_d = conv_rise ? CONVERT :
              conv_done ? READY :
              (state == READY && sck_rise) ? SHIFT : state;
  end
  // sample shifting, config capture and status pulses
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      shift <= '0;
      bit_cnt <= '0;
      cfg_part <= '0;
      cfg_word <= '0;
      cfg_valid <= 1'b0;
      sck_early <= 1'b0;
      chan <= '0;
      sdo <= 1'b0;
    end else begin
      cfg_valid <= 1'b0;
      sck_early <= sck_rise && state == CONVERT;
      chan <= cfg_word[4:2];
      if (conv_rise) begin
        shift <= sample_in;
        cnt <= '0;
        bit_cnt <= '0;
        cfg_part <= '0;
        sdo <= 1'b0;
      end else begin
        if (state == CONVERT) cnt <= cnt + 1'b1;
        if (conv_done) sdo <= shift[11];
        if (shift_en) begin
          shift <= {shift[10:0], 1'b0};
          sdo <= shift[10];
          if (bit_cnt < 3'd6) begin
            cfg_part <= {cfg_part[4:0], sdi_q[1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd5) begin
              cfg_word <= {cfg_part[4:0], sdi_q[1]};
              cfg_valid <= 1'b1;
            end
          end
        end
      end
    end
endmodule

// File: tb/tb_adc_spi_responder.sv
// tb_adc_spi_responder: reader-style stimulus with scoreboarded samples and config words
module tb_adc_spi_responder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [11:0] sample_in = '0;
  logic busy, cfg_valid, sck_early;
  logic [2:0] chan;
  logic [5:0] cfg_word;
  adc_spi_if bus();
  adc_spi_responder #(.CONV_CYCLES(64)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave), .sample_in(sample_in), .busy(busy),
    .chan(chan), .cfg_word(cfg_word), .cfg_valid(cfg_valid), .sck_early(sck_early)
  );
  always #5 clk = ~clk;
  int total = 0, bad = 0, t_conv = 0, n_early = 0, n_valid = 0;
  logic [11:0] exp_q[$];
  logic [5:0] cfg_q[$];
  logic chan_due = 1'b0, prev_valid = 1'b0;
  logic [5:0] chan_cfg = '0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    t_conv += n;
  endtask
  task automatic start_conv(input logic [11:0] s);
    sample_in = s;
    exp_q.push_back(s);
    bus.CONVST = 1'b1;
    t_conv = 0;
    tick(2);
    check("busy_pre", 32'(busy), 0);
    bus.CONVST = 1'b0;
    tick(1);
    check("busy_on", 32'(busy), 1);
  endtask
  task automatic wait_ready();
    tick(80 - t_conv);
    check("ready", 32'(busy), 0);
  endtask
  task automatic read_frame(input logic [5:0] cfg, input int nbits);
    logic [11:0] got = '0;
    if (nbits >= 6) cfg_q.push_back(cfg);
    for (int i = 0; i < nbits; i++) begin
      bus.SDI = i < 6 ? cfg[5 - i] : 1'b0;
      got = {got[10:0], bus.SDO};
      bus.SCK = 1'b1;
      tick(4);
      bus.SCK = 1'b0;
      tick(4);
    end
    if (nbits == 12) check("frame", 32'(got), 32'(exp_q.pop_front()));
  endtask
  task automatic run_frame(input logic [11:0] s, input logic [5:0] cfg);
    start_conv(s);
    wait_ready();
    read_frame(cfg, 12);
  endtask
  task automatic check_reset_outputs();
    check("rst_sdo", 32'(bus.SDO), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_chan", 32'(chan), 0);
    check("rst_cfg", 32'(cfg_word), 0);
    check("rst_valid", 32'(cfg_valid), 0);
    check("rst_early", 32'(sck_early), 0);
  endtask
  // config word, pulse width and channel follow-up monitor
  always @(negedge clk) begin
    if (chan_due) check("chan", 32'(chan), 32'(chan_cfg[4:2]));
    chan_due = 1'b0;
    if (sck_early) n_early++;
    if (cfg_valid) begin
      n_valid++;
      check("valid_width", 32'(prev_valid), 0);
      check("cfg_expected", 32'(cfg_q.size() > 0), 1);
      if (cfg_q.size() > 0) begin
        chan_cfg = cfg_q.pop_front();
        check("cfg_word", 32'(cfg_word), 32'(chan_cfg));
        chan_due = 1'b1;
      end
    end
    prev_valid = cfg_valid;
  end
  initial begin
    logic [11:0] b2b [4] = '{12'h000, 12'hFFF, 12'h800, 12'h001};
    logic [5:0] b2b_cfg [4] = '{6'b010111, 6'b101000, 6'b111111, 6'b000000};
    int n, v;
    logic [5:0] cw;
    bus.CONVST = 1'b0;
    bus.SCK = 1'b0;
    bus.SDI = 1'b0;
    tick(3);
    check_reset_outputs();
    rst_n = 1'b1;
    tick(3);
    // nominal frame with conversion length measurement
    start_conv(12'hA5C);
    n = 1;
    while (busy && n < 200) begin
      tick(1);
      n++;
    end
    check("busy_len", 32'(n - 1), 64);
    wait_ready();
    read_frame(6'b100010, 12);
    tick(5);
    // sample_in changes right after it was latched
    start_conv(12'hA5C);
    sample_in = 12'h123;
    wait_ready();
    read_frame(6'b011100, 12);
    run_frame(12'h123, 6'b001000);
    // SCK rise during conversion
    v = n_early;
    start_conv(12'h9C6);
    tick(17);
    bus.SCK = 1'b1;
    tick(4);
    bus.SCK = 1'b0;
    tick(4);
    check("early_pulse", 32'(n_early - v), 1);
    check("early_sdo", 32'(bus.SDO), 0);
    wait_ready();
    read_frame(6'b110011, 12);
    // abort after three config bits
    start_conv(12'h3C3);
    wait_ready();
    v = n_valid;
    cw = cfg_word;
    read_frame(6'b011011, 3);
    void'(exp_q.pop_front());
    start_conv(12'h5A5);
    tick(10);
    check("abort_cfg", 32'(cfg_word), 32'(cw));
    check("abort_valid", 32'(n_valid - v), 0);
    wait_ready();
    read_frame(6'b110100, 12);
    // reset in the middle of shifting
    start_conv(12'h6E1);
    wait_ready();
    read_frame(6'b001110, 5);
    void'(exp_q.pop_front());
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    tick(2);
    rst_n = 1'b1;
    tick(3);
    run_frame(12'h9B7, 6'b011100);
    // back-to-back frames
    for (int i = 0; i < 4; i++) run_frame(b2b[i], b2b_cfg[i]);
    tick(5);
    check("exp_q_empty", 32'(exp_q.size()), 0);
    check("cfg_q_empty", 32'(cfg_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
